// File: rtl/instruction_fetch_if.sv
// Signal bundle between the instruction fetch unit, program memory, the bus
// arbiter and pipeline_stage1.
interface instruction_fetch_if;
  // Memory read handshake: the fetch unit holds mem_rd_n low with mem_addr
  // stable until a posedge that sees mem_ready=1 takes the byte on mem_data.
  // Releasing the strobe before that edge (bus hand-off, PC load, fetch
  // suppression) abandons the read; nothing is taken from mem_data.
  logic [15:0] mem_addr;
  logic        mem_rd_n;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        fetch_suppress;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        bus_request;
  logic        bus_grant;
  logic [7:0]  instruction;
  logic        instruction_valid;
  logic [15:0] pc;
  logic        flag_reset_out;

  modport master (
    output mem_addr, mem_rd_n, bus_grant, instruction, instruction_valid, pc, flag_reset_out,
    input  mem_data, mem_ready, fetch_suppress, pc_load, pc_load_value, bus_request
  );

  modport slave (
    input  mem_addr, mem_rd_n, bus_grant, instruction, instruction_valid, pc, flag_reset_out,
    output mem_data, mem_ready, fetch_suppress, pc_load, pc_load_value, bus_request
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: reads one opcode byte per clock at the PC and
// hands it to stage1, inserting NOP bubbles on waits, suppression, loads and bus hand-off.
module instruction_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          RESET_CYCLES = 4,
  parameter logic [7:0]  NOP_OPCODE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.master   bus,
  output logic [1:0]            fsm_state
);

  // Encoding is visible on fsm_state: 0 = RESET, 1 = FETCH, 2 = HOLD.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] RST_CNT_INIT = CW'(RESET_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] rst_cnt, rst_cnt_next;
  logic [15:0]   pc_q, pc_next;
  logic [7:0]    instr_q, instr_next;
  logic          valid_q, valid_next;
  logic          flag_q, flag_next;
  logic          grant_q, grant_next;
  logic          read_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_RESET;
      rst_cnt <= RST_CNT_INIT;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_OPCODE;
      valid_q <= 1'b0;
      flag_q  <= 1'b1;
      grant_q <= 1'b0;
    end else begin
      state   <= state_next;
      rst_cnt <= rst_cnt_next;
      pc_q    <= pc_next;
      instr_q <= instr_next;
      valid_q <= valid_next;
      flag_q  <= flag_next;
      grant_q <= grant_next;
    end
  end

  // The strobe drops the moment any higher-priority request appears, so an
  // unaccepted read is never completed behind a hand-off or load.
  assign read_en = (state == ST_FETCH) && !bus.fetch_suppress &&
                   !bus.bus_request && !bus.pc_load;

  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    pc_next      = pc_q;
    instr_next   = NOP_OPCODE;
    valid_next   = 1'b0;
    flag_next    = flag_q;
    grant_next   = grant_q;

    case (state)
      ST_RESET: begin
        if (rst_cnt == '0) begin
          state_next = ST_FETCH;
          flag_next  = 1'b0;
        end else begin
          rst_cnt_next = rst_cnt - 1'b1;
        end
      end
      ST_FETCH: begin
        if (bus.bus_request) begin
          state_next = ST_HOLD;
          grant_next = 1'b1;
        end else if (bus.pc_load) begin
          pc_next = bus.pc_load_value;
        end else if (bus.fetch_suppress) begin
          pc_next = pc_q;
        end else if (bus.mem_ready) begin
          instr_next = bus.mem_data;
          valid_next = 1'b1;
          pc_next    = pc_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (bus.pc_load) pc_next = bus.pc_load_value;
        if (!bus.bus_request) begin
          state_next = ST_FETCH;
          grant_next = 1'b0;
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  assign bus.mem_addr          = pc_q;
  assign bus.mem_rd_n          = !read_en;
  assign bus.pc                = pc_q;
  assign bus.instruction       = instr_q;
  assign bus.instruction_valid = valid_q;
  assign bus.flag_reset_out    = flag_q;
  assign bus.bus_grant         = grant_q;
  assign fsm_state             = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// traffic, compared against a cycle-level reference model of the fetch rules.
module tb_instruction_fetch;

  localparam logic [15:0] RESET_VECTOR = 16'h0000;
  localparam int          RESET_CYCLES = 4;
  localparam logic [7:0]  NOP_OPCODE   = 8'h00;

  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_VECTOR (RESET_VECTOR),
    .RESET_CYCLES (RESET_CYCLES),
    .NOP_OPCODE   (NOP_OPCODE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_pc;
  logic [7:0]  m_instr;
  logic        m_valid;
  logic        m_flag;
  logic        m_grant;
  int          m_rst_left;
  bit          m_hold;
  logic [7:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = RESET_VECTOR;
    m_instr    = NOP_OPCODE;
    m_valid    = 1'b0;
    m_flag     = 1'b1;
    m_grant    = 1'b0;
    m_rst_left = RESET_CYCLES;
    m_hold     = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic model_reads(input logic sup, input logic pl, input logic breq);
    return (m_rst_left == 0) && !m_hold && !sup && !breq && !pl;
  endfunction

  task automatic model_step(input logic sup, input logic pl, input logic [15:0] plv,
                            input logic breq, input logic rdy, input logic [7:0] data);
    m_instr = NOP_OPCODE;
    m_valid = 1'b0;
    if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_flag = 1'b0;
    end else if (m_hold) begin
      if (pl) m_pc = plv;
      if (!breq) begin
        m_hold  = 1'b0;
        m_grant = 1'b0;
      end
    end else if (breq) begin
      m_hold  = 1'b1;
      m_grant = 1'b1;
    end else if (pl) begin
      m_pc = plv;
    end else if (!sup && rdy) begin
      m_instr = data;
      m_valid = 1'b1;
      m_pc    = m_pc + 16'd1;
      exp_q.push_back(data);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_state;
    exp_state = (m_rst_left > 0) ? 2'd0 : (m_hold ? 2'd2 : 2'd1);
    check_eq("instruction", bus.instruction, m_instr);
    check_eq("valid", bus.instruction_valid, m_valid);
    check_eq("pc", bus.pc, m_pc);
    check_eq("bus_grant", bus.bus_grant, m_grant);
    check_eq("flag_reset", bus.flag_reset_out, m_flag);
    check_eq("fsm_state", fsm_state, exp_state);
    if (bus.instruction_valid === 1'b1) begin
      if (exp_q.size() > 0) check_eq("stream", bus.instruction, exp_q.pop_front());
      else check_eq("stream_extra", bus.instruction_valid, 1'b0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic sup, input logic pl, input logic [15:0] plv,
                       input logic breq, input logic rdy, input logic [7:0] data);
    bus.fetch_suppress = sup;
    bus.pc_load        = pl;
    bus.pc_load_value  = plv;
    bus.bus_request    = breq;
    bus.mem_ready      = rdy;
    bus.mem_data       = data;
    #1;
    check_eq("mem_addr", bus.mem_addr, m_pc);
    check_eq("mem_rd_n", bus.mem_rd_n, !model_reads(sup, pl, breq));
    @(posedge clk);
    model_step(sup, pl, plv, breq, rdy, data);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic fetch_cycle(input logic rdy);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, rdy, m_pc[7:0]);
  endtask

  task automatic load_pc(input logic [15:0] v);
    cycle(1'b0, 1'b1, v, 1'b0, 1'b1, 8'hA5);
  endtask

  // Reset asserted between clock edges; outputs must respond without an edge.
  task automatic async_reset_pulse();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_grant", bus.bus_grant, 1'b0);
    check_eq("arst_flag", bus.flag_reset_out, 1'b1);
    check_eq("arst_valid", bus.instruction_valid, 1'b0);
    check_eq("arst_instr", bus.instruction, NOP_OPCODE);
    check_eq("arst_pc", bus.pc, RESET_VECTOR);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t2_exp [4];
  int         breq_left;

  initial begin
    t2_exp[0] = 8'hFE; t2_exp[1] = 8'hFF; t2_exp[2] = 8'h00; t2_exp[3] = 8'h01;
    reset = 1'b1;
    bus.fetch_suppress = 1'b0;
    bus.pc_load        = 1'b0;
    bus.pc_load_value  = 16'h0;
    bus.bus_request    = 1'b0;
    bus.mem_ready      = 1'b0;
    bus.mem_data       = 8'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // T1: inputs are ignored while the power-on count runs.
    for (int i = 0; i < RESET_CYCLES; i++) begin
      check_eq("t1_flag_hi", bus.flag_reset_out, 1'b1);
      cycle(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 8'h77);
    end
    check_eq("t1_flag_lo", bus.flag_reset_out, 1'b0);
    bus.pc_load = 1'b0;
    bus.bus_request = 1'b0;
    #1;
    check_eq("t1_addr", bus.mem_addr, 16'h0000);
    check_eq("t1_rd_n", bus.mem_rd_n, 1'b0);

    // T2: PC wrap.
    load_pc(16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      fetch_cycle(1'b1);
      check_eq("t2_instr", bus.instruction, t2_exp[i]);
    end
    check_eq("t2_pc", bus.pc, 16'h0002);

    // T3: memory wait.
    load_pc(16'h0010);
    fetch_cycle(1'b0);
    fetch_cycle(1'b0);
    check_eq("t3_pc_held", bus.pc, 16'h0010);
    fetch_cycle(1'b1);
    check_eq("t3_instr", bus.instruction, 8'h10);
    check_eq("t3_pc", bus.pc, 16'h0011);

    // T4: fetch suppression.
    load_pc(16'h0020);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 8'h20);
    check_eq("t4_nop", bus.instruction_valid, 1'b0);
    check_eq("t4_pc", bus.pc, 16'h0020);
    fetch_cycle(1'b1);
    check_eq("t4_instr", bus.instruction, 8'h20);

    // T5: bus hand-off aborts a pending read.
    load_pc(16'h0030);
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h30);
    check_eq("t5_grant", bus.bus_grant, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h30);
    check_eq("t5_release", bus.bus_grant, 1'b0);
    fetch_cycle(1'b1);
    check_eq("t5_instr", bus.instruction, 8'h30);
    check_eq("t5_pc", bus.pc, 16'h0031);

    // T6: load beats suppress; then reset lands mid-HOLD.
    cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 8'h55);
    check_eq("t6_pc", bus.pc, 16'h1234);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
    check_eq("t6_hold", bus.bus_grant, 1'b1);
    async_reset_pulse();

    // Randomized traffic.
    breq_left = 0;
    for (int i = 0; i < 2000; i++) begin
      logic sup, pl, breq, rdy;
      if (breq_left > 0) breq_left--;
      else if ($urandom_range(0, 19) == 0) breq_left = $urandom_range(1, 4);
      breq = (breq_left > 0);
      sup  = ($urandom_range(0, 5) == 0);
      pl   = ($urandom_range(0, 15) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      cycle(sup, pl, 16'($urandom), breq, rdy, 8'($urandom));
      if ($urandom_range(0, 399) == 0) async_reset_pulse();
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
